hgcal_fc_cmd_scheduler: RTL and testbench
=========================================

# hgcal_fc_cmd_scheduler

Per-bunch-crossing fast-command scheduler feeding the HGCAL fast-control encoder. It keeps the bunch-crossing and orbit counters and latches sticky requests from the register interface and trigger logic. Every 40 MHz cycle it selects exactly one command by fixed priority, with orbit-aligned commands locked to the orbit-sync slot. The registered command code drives the 8-bit stream encoder, followed by the 320 MHz serializer.

## Interface
Parameters:
- ORBIT_LEN, 3564: BX per orbit; bx_count wraps at ORBIT_LEN-1.
- SYNC_BX, 3563: BX of the orbit-sync/OCR slot.
- CALIB_DELAY, 20: BX from CALIB_REQ to its CALIB_L1A; legal range 2..255.
- CALIB_BX, 100: BX for periodic calibration requests.

Ports:
- clk40  in  1  40 MHz LHC clock; sole clock.
- reset  in  1  synchronous, active-high.
- orbit_sync_en  in  1  emit ORBIT_SYNC in the sync slot.
- l1a_en  in  1  accept l1a_req.
- req_linkreset  in  1  one-cycle request pulse.
- req_daqreset  in  1  one-cycle request pulse.
- req_ocr  in  1  one-cycle request pulse.
- req_calib  in  1  one-cycle request pulse.
- l1a_req  in  1  one-cycle trigger pulse.
- periodic_calib_en  in  1  periodic calibration enable (see Configuration).
- cmd  out  3  command for this BX: 0 IDLE, 1 ORBIT_SYNC, 2 OCR, 3 LINK_RESET, 4 DAQ_RESET, 5 CALIB_REQ, 6 L1A, 7 CALIB_L1A.
- bx_count  out  12  BX of the current cmd.
- orbit_count  out  32  orbit number.
- l1a_dropped  out  1  one-cycle pulse when l1a_req is lost.
- busy  out  1  any request pending or calibration delay running.

## Operation
- Each request sets a sticky pending flag. A repeat request while the flag is set merges into it. The flag clears in the cycle its command is issued.
- l1a_req with l1a_en=0 is ignored. l1a_req while L1A is already pending pulses l1a_dropped.
- Slot selection for the next BX:
  - When next bx == SYNC_BX: OCR if pending; else ORBIT_SYNC if orbit_sync_en; else the normal priority below.
  - Normal priority: CALIB_L1A due > L1A > LINK_RESET > DAQ_RESET > CALIB_REQ > IDLE.
- OCR is issued only in the sync slot, whether or not orbit_sync_en is set.
- Calibration:
  - Issuing CALIB_REQ at BX b loads the delay counter.
  - CALIB_L1A becomes due at b+CALIB_DELAY, modulo ORBIT_LEN.
  - CALIB_REQ is not issued while the counter runs. A new req_calib stays pending until the CALIB_L1A has been issued.
  - A due CALIB_L1A that loses the sync slot stays due and goes out in the next BX.
- orbit_count: +1 when bx_count wraps to 0. If OCR was issued in the preceding sync slot, it loads 0 instead.
- Reset clears every pending flag and the delay counter, and aborts any calibration in flight.

## Timing
- Outputs are registered. A request sampled at edge n is issued at the earliest on cmd after edge n+1.
- Reset values: cmd=0, bx_count=0, orbit_count=0, l1a_dropped=0, busy=0.
- First cycle after reset release: cmd=IDLE, bx_count=0.
- bx_count increments by 1 each cycle and wraps ORBIT_LEN-1 -> 0.
- A request and the issue of its command in the same cycle: the flag ends up set. The new request is not consumed.
- Simultaneous requests issue one per BX, in priority order, on consecutive cycles unless preempted.

## Configuration
- PERIODIC_CALIB_EN defined:
  - With periodic_calib_en=1, req_calib is set automatically every orbit when next bx == CALIB_BX.
  - It merges with any pending manual request.
- Undefined:
  - periodic_calib_en is ignored and the periodic logic is not compiled.
  - Only req_calib starts calibrations.

## Test plan
- Reset then orbit_sync_en=1 -> cmd=1 at bx_count 3563 every 3564 cycles; IDLE elsewhere; orbit_count steps 0->1 at the first wrap.
- req_linkreset and req_daqreset in the same cycle n -> LINK_RESET at n+1, DAQ_RESET at n+2, busy low after.
- req_ocr at bx 1000 -> cmd=2 at bx 3563 with no ORBIT_SYNC that orbit; orbit_count=0 at the following bx 0.
- req_calib issued at bx 3550 -> CALIB_REQ at 3550, CALIB_L1A due at 3570 mod 3564 = 6, cmd=7 at bx 6.
  - Variant: first CALIB_REQ issued at bx 3543, so CALIB_L1A is due at 3563. The sync slot wins and CALIB_L1A goes out at bx 0.
- l1a_en=1, l1a_req on two consecutive cycles while LINK_RESET is pending -> L1A once, l1a_dropped pulses once, LINK_RESET follows.
- PERIODIC_CALIB_EN defined with periodic_calib_en=1 -> CALIB_REQ at bx 100 and CALIB_L1A at bx 120 every orbit.
  - Reset asserted at bx 110 -> no CALIB_L1A; counters restart from 0.

Source files
------------

// File: rtl/hgcal_fc_cmd_scheduler.sv
// HGCAL fast-command scheduler: one registered command per BX, chosen by fixed priority.
// Optional build macro PERIODIC_CALIB_EN adds the once-per-orbit automatic calibration request.
module hgcal_fc_cmd_scheduler #(
  parameter int ORBIT_LEN   = 3564,
  parameter int SYNC_BX     = 3563,
  parameter int CALIB_DELAY = 20,
  parameter int CALIB_BX    = 100
) (
  input  logic        clk40,
  input  logic        reset,
  input  logic        orbit_sync_en,
  input  logic        l1a_en,
  input  logic        req_linkreset,
  input  logic        req_daqreset,
  input  logic        req_ocr,
  input  logic        req_calib,
  input  logic        l1a_req,
  input  logic        periodic_calib_en,
  output logic [2:0]  cmd,
  output logic [11:0] bx_count,
  output logic [31:0] orbit_count,
  output logic        l1a_dropped,
  output logic        busy
);

  typedef enum logic [2:0] {
    CMD_IDLE       = 3'd0,
    CMD_ORBIT_SYNC = 3'd1,
    CMD_OCR        = 3'd2,
    CMD_LINK_RESET = 3'd3,
    CMD_DAQ_RESET  = 3'd4,
    CMD_CALIB_REQ  = 3'd5,
    CMD_L1A        = 3'd6,
    CMD_CALIB_L1A  = 3'd7
  } cmd_e;

  localparam logic [11:0] BX_LAST = 12'(ORBIT_LEN - 1);
  localparam logic [11:0] BX_SYNC = 12'(SYNC_BX);
  localparam logic [11:0] BX_CAL  = 12'(CALIB_BX);
  localparam logic [7:0]  CAL_DLY = 8'(CALIB_DELAY);

  function automatic logic [11:0] bx_inc(input logic [11:0] bx);
    return (bx == BX_LAST) ? 12'd0 : bx + 12'd1;
  endfunction

  cmd_e        cmd_q, cmd_d;
  logic [11:0] bx_q, bx_d;
  logic [31:0] orbit_q, orbit_d;
  logic        drop_q, drop_d;
  logic        busy_q, busy_d;
  logic        pend_ocr_q, pend_ocr_d;
  logic        pend_lr_q, pend_lr_d;
  logic        pend_dr_q, pend_dr_d;
  logic        pend_cal_q, pend_cal_d;
  logic        pend_l1a_q, pend_l1a_d;
  logic [7:0]  cal_cnt_q, cal_cnt_d;
  logic        cal_due_q, cal_due_d;
  logic        ocr_done_q, ocr_done_d;

  logic        periodic_hit;
  logic        sync_slot;
  logic        cal_due;
  logic        cal_req_pend;
  logic        cal_req_ok;
  logic        l1a_acc;

`ifdef PERIODIC_CALIB_EN
  // The automatic request must be eligible in the CALIB_BX slot itself, so it
  // joins selection combinationally rather than through the pending flag.
  assign periodic_hit = periodic_calib_en && (bx_d == BX_CAL);
`else
  logic unused_periodic;
  assign unused_periodic = periodic_calib_en;
  assign periodic_hit    = 1'b0;
`endif

  assign bx_d         = bx_inc(bx_q);
  assign sync_slot    = (bx_d == BX_SYNC);
  assign cal_due      = cal_due_q || (cal_cnt_q == 8'd1);
  assign cal_req_pend = pend_cal_q || periodic_hit;
  assign cal_req_ok   = cal_req_pend && (cal_cnt_q == 8'd0) && !cal_due_q;
  assign l1a_acc      = l1a_req && l1a_en;

  always_comb begin
    cmd_d = CMD_IDLE;
    if (sync_slot && pend_ocr_q)         cmd_d = CMD_OCR;
    else if (sync_slot && orbit_sync_en) cmd_d = CMD_ORBIT_SYNC;
    else if (cal_due)                    cmd_d = CMD_CALIB_L1A;
    else if (pend_l1a_q)                 cmd_d = CMD_L1A;
    else if (pend_lr_q)                  cmd_d = CMD_LINK_RESET;
    else if (pend_dr_q)                  cmd_d = CMD_DAQ_RESET;
    else if (cal_req_ok)                 cmd_d = CMD_CALIB_REQ;
  end

  // A request arriving in its own issue cycle re-arms the flag; a second
  // L1A while one is already queued is dropped instead.
  always_comb begin
    pend_ocr_d = req_ocr       || (pend_ocr_q   && (cmd_d != CMD_OCR));
    pend_lr_d  = req_linkreset || (pend_lr_q    && (cmd_d != CMD_LINK_RESET));
    pend_dr_d  = req_daqreset  || (pend_dr_q    && (cmd_d != CMD_DAQ_RESET));
    pend_cal_d = req_calib     || (cal_req_pend && (cmd_d != CMD_CALIB_REQ));
    pend_l1a_d = (pend_l1a_q && (cmd_d != CMD_L1A)) || (l1a_acc && !pend_l1a_q);
    drop_d     = l1a_acc && pend_l1a_q;

    cal_cnt_d = cal_cnt_q;
    if (cmd_d == CMD_CALIB_REQ)  cal_cnt_d = CAL_DLY;
    else if (cal_cnt_q != 8'd0)  cal_cnt_d = cal_cnt_q - 8'd1;
    cal_due_d = cal_due && (cmd_d != CMD_CALIB_L1A);

    ocr_done_d = (cmd_d == CMD_OCR) || (ocr_done_q && (bx_d != 12'd0));
    orbit_d    = orbit_q;
    if (bx_d == 12'd0) orbit_d = ocr_done_q ? 32'd0 : orbit_q + 32'd1;

    busy_d = pend_ocr_d || pend_lr_d || pend_dr_d || pend_cal_d || pend_l1a_d ||
             (cal_cnt_d != 8'd0) || cal_due_d;
  end

  always_ff @(posedge clk40) begin
    if (reset) begin
      cmd_q      <= CMD_IDLE;
      bx_q       <= 12'd0;
      orbit_q    <= 32'd0;
      drop_q     <= 1'b0;
      busy_q     <= 1'b0;
      pend_ocr_q <= 1'b0;
      pend_lr_q  <= 1'b0;
      pend_dr_q  <= 1'b0;
      pend_cal_q <= 1'b0;
      pend_l1a_q <= 1'b0;
      cal_cnt_q  <= 8'd0;
      cal_due_q  <= 1'b0;
      ocr_done_q <= 1'b0;
    end else begin
      cmd_q      <= cmd_d;
      bx_q       <= bx_d;
      orbit_q    <= orbit_d;
      drop_q     <= drop_d;
      busy_q     <= busy_d;
      pend_ocr_q <= pend_ocr_d;
      pend_lr_q  <= pend_lr_d;
      pend_dr_q  <= pend_dr_d;
      pend_cal_q <= pend_cal_d;
      pend_l1a_q <= pend_l1a_d;
      cal_cnt_q  <= cal_cnt_d;
      cal_due_q  <= cal_due_d;
      ocr_done_q <= ocr_done_d;
    end
  end

  assign cmd         = cmd_q;
  assign bx_count    = bx_q;
  assign orbit_count = orbit_q;
  assign l1a_dropped = drop_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_hgcal_fc_cmd_scheduler.sv
// Directed bench for hgcal_fc_cmd_scheduler; inputs change and outputs are sampled on the falling edge.
module tb_hgcal_fc_cmd_scheduler;

  logic        clk40 = 1'b0;
  logic        reset = 1'b1;
  logic        orbit_sync_en = 1'b0;
  logic        l1a_en = 1'b0;
  logic        req_linkreset = 1'b0;
  logic        req_daqreset = 1'b0;
  logic        req_ocr = 1'b0;
  logic        req_calib = 1'b0;
  logic        l1a_req = 1'b0;
  logic        periodic_calib_en = 1'b0;
  logic [2:0]  cmd;
  logic [11:0] bx_count;
  logic [31:0] orbit_count;
  logic        l1a_dropped;
  logic        busy;

  int errors = 0;
  int checks = 0;

  hgcal_fc_cmd_scheduler dut (
    .clk40(clk40), .reset(reset), .orbit_sync_en(orbit_sync_en), .l1a_en(l1a_en),
    .req_linkreset(req_linkreset), .req_daqreset(req_daqreset), .req_ocr(req_ocr),
    .req_calib(req_calib), .l1a_req(l1a_req), .periodic_calib_en(periodic_calib_en),
    .cmd(cmd), .bx_count(bx_count), .orbit_count(orbit_count),
    .l1a_dropped(l1a_dropped), .busy(busy)
  );

  always #12 clk40 = ~clk40;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk40);
  endtask

  task automatic wait_bx(input int target);
    int n = 0;
    while (bx_count != 12'(target) && n < 8000) begin
      step();
      n++;
    end
    if (n >= 8000) check("wait_bx_timeout", 32'(bx_count), 32'(target));
  endtask

  initial begin
    int extra;
    repeat (3) step();
    check("rst_cmd", 32'(cmd), 0);
    check("rst_bx", 32'(bx_count), 0);
    check("rst_orbit", orbit_count, 0);
    check("rst_drop", 32'(l1a_dropped), 0);
    check("rst_busy", 32'(busy), 0);

    // Orbit sync slot and orbit counter
    reset = 1'b0;
    orbit_sync_en = 1'b1;
    step();
    check("first_bx", 32'(bx_count), 1);
    check("first_cmd", 32'(cmd), 0);
    wait_bx(3563);
    check("sync0_cmd", 32'(cmd), 1);
    check("sync0_orbit", orbit_count, 0);
    step();
    check("wrap_bx", 32'(bx_count), 0);
    check("wrap_orbit", orbit_count, 1);
    check("wrap_cmd", 32'(cmd), 0);
    extra = 0;
    for (int i = 0; i < 3563; i++) begin
      step();
      if (cmd != 3'd0 && bx_count != 12'd3563) extra++;
    end
    check("orbit1_idle", 32'(extra), 0);
    check("sync1_bx", 32'(bx_count), 3563);
    check("sync1_cmd", 32'(cmd), 1);
    step();
    check("orbit2", orbit_count, 2);

    // Simultaneous link/daq resets
    wait_bx(10);
    req_linkreset = 1'b1;
    req_daqreset = 1'b1;
    step();
    req_linkreset = 1'b0;
    req_daqreset = 1'b0;
    check("lr_early_cmd", 32'(cmd), 0);
    check("lr_busy", 32'(busy), 1);
    step();
    check("lr_cmd", 32'(cmd), 3);
    step();
    check("dr_cmd", 32'(cmd), 4);
    check("dr_busy_low", 32'(busy), 0);

    // Back-to-back L1A with LINK_RESET pending
    wait_bx(20);
    l1a_en = 1'b1;
    req_linkreset = 1'b1;
    l1a_req = 1'b1;
    step();
    req_linkreset = 1'b0;
    check("l1a_early_cmd", 32'(cmd), 0);
    check("l1a_early_drop", 32'(l1a_dropped), 0);
    step();
    l1a_req = 1'b0;
    check("l1a_cmd", 32'(cmd), 6);
    check("l1a_drop", 32'(l1a_dropped), 1);
    step();
    check("l1a_lr_cmd", 32'(cmd), 3);
    check("l1a_drop_once", 32'(l1a_dropped), 0);
    step();
    check("l1a_once", 32'(cmd), 0);
    l1a_en = 1'b0;
    l1a_req = 1'b1;
    step();
    l1a_req = 1'b0;
    step();
    check("l1a_dis_cmd", 32'(cmd), 0);
    check("l1a_dis_busy", 32'(busy), 0);

    // OCR held to the sync slot
    wait_bx(1000);
    req_ocr = 1'b1;
    step();
    req_ocr = 1'b0;
    wait_bx(3562);
    check("ocr_wait_cmd", 32'(cmd), 0);
    check("ocr_wait_busy", 32'(busy), 1);
    step();
    check("ocr_cmd", 32'(cmd), 2);
    step();
    check("ocr_orbit", orbit_count, 0);
    check("ocr_busy", 32'(busy), 0);

    // Calibration wrapping across the orbit boundary
    wait_bx(3548);
    req_calib = 1'b1;
    step();
    req_calib = 1'b0;
    step();
    check("cal_req_bx", 32'(bx_count), 3550);
    check("cal_req_cmd", 32'(cmd), 5);
    wait_bx(3563);
    check("cal_sync_cmd", 32'(cmd), 1);
    check("cal_busy", 32'(busy), 1);
    wait_bx(5);
    check("cal_pre_cmd", 32'(cmd), 0);
    req_calib = 1'b1;
    step();
    req_calib = 1'b0;
    check("cal_l1a_cmd", 32'(cmd), 7);
    step();
    check("cal_req2_cmd", 32'(cmd), 5);
    wait_bx(27);
    check("cal_l1a2_cmd", 32'(cmd), 7);
    step();
    check("cal_busy_low", 32'(busy), 0);

    // CALIB_L1A due in the sync slot slips to BX 0
    wait_bx(3541);
    req_calib = 1'b1;
    step();
    req_calib = 1'b0;
    step();
    check("slip_req_cmd", 32'(cmd), 5);
    wait_bx(3563);
    check("slip_sync_cmd", 32'(cmd), 1);
    step();
    check("slip_bx", 32'(bx_count), 0);
    check("slip_cmd", 32'(cmd), 7);
    check("slip_orbit", orbit_count, 2);

`ifdef PERIODIC_CALIB_EN
    periodic_calib_en = 1'b1;
    wait_bx(100);
    check("per_req_cmd", 32'(cmd), 5);
    wait_bx(120);
    check("per_l1a_cmd", 32'(cmd), 7);
    wait_bx(100);
    check("per_req2_cmd", 32'(cmd), 5);
    check("per_req2_orbit", orbit_count, 3);
    wait_bx(110);
    reset = 1'b1;
    step();
    check("per_rst_bx", 32'(bx_count), 0);
    check("per_rst_orbit", orbit_count, 0);
    check("per_rst_busy", 32'(busy), 0);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (cmd == 3'd7) extra++;
    end
    check("per_abort_no_l1a", 32'(extra), 0);
    check("per_restart_bx", 32'(bx_count), 60);
`else
    periodic_calib_en = 1'b1;
    wait_bx(100);
    check("noper_cmd", 32'(cmd), 0);
    wait_bx(120);
    check("noper_l1a_cmd", 32'(cmd), 0);
    check("noper_busy", 32'(busy), 0);
`endif

    // Reset aborts a manual calibration in flight
    periodic_calib_en = 1'b0;
    req_calib = 1'b1;
    step();
    req_calib = 1'b0;
    step();
    check("abort_req_cmd", 32'(cmd), 5);
    repeat (5) step();
    reset = 1'b1;
    step();
    check("abort_busy", 32'(busy), 0);
    check("abort_cmd", 32'(cmd), 0);
    reset = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (cmd == 3'd7) extra++;
    end
    check("abort_no_l1a", 32'(extra), 0);
    check("abort_busy_after", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
